mtm_alu_core: RTL

//  Execution stage directly downstream of the ALU serial deserializer. Consumes parallel A/B/CTL words.

---
 rtl/mtm_alu_pkg.sv | 28 ++
 rtl/mtm_alu_crc3.sv | 16 +
 rtl/mtm_alu_core.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mtm_alu_pkg.sv
// Shared constants and types for the ALU execution stage and its neighbours
// (op codes, error bytes, idle marker, FSM states, flag positions).
package mtm_alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  localparam logic [7:0] IDLE_CTL = 8'hFF;
  localparam logic [7:0] ERR_DATA = 8'hC9;
  localparam logic [7:0] ERR_CRC  = 8'hA5;
  localparam logic [7:0] ERR_OP   = 8'h93;

  // Bit positions inside the 4-bit {Cy,V,Z,N} flag nibble
  localparam int FLAG_CY = 3;
  localparam int FLAG_V  = 2;
  localparam int FLAG_Z  = 1;
  localparam int FLAG_N  = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_CRC,
    ST_OUT
  } state_t;

endpackage

// File: rtl/mtm_alu_crc3.sv
// Combinational CRC3 (x^3+x+1, init 0) over a 37-bit word, MSB first.
// Shared by the execution stage and the serializer-side checker.
module mtm_alu_crc3 (
  input  logic [36:0] data,
  output logic [2:0]  crc
);

  always_comb begin
    crc = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      if (crc[2] ^ data[i]) crc = {crc[1:0], 1'b0} ^ 3'b011;
      else                  crc = {crc[1:0], 1'b0};
    end
  end

endmodule

// File: rtl/mtm_alu_core.sv
// ALU execution stage: detects a new command on the deserializer's CTL word,
// executes it, builds the response control byte and hands it out over valid/ready.
module mtm_alu_core #(
  parameter logic [7:0] IDLE_CTL = mtm_alu_pkg::IDLE_CTL,
  parameter int         OVF_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      A,
  input  logic [31:0]      B,
  input  logic [7:0]       CTL,
  output logic [31:0]      C,
  output logic [7:0]       ctl_out,
  output logic             err_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OVF_W-1:0] ovf_cnt
);
  import mtm_alu_pkg::*;

  function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
    return (&v) ? v : v + {{(OVF_W-1){1'b0}}, 1'b1};
  endfunction

  state_t             state, state_nx;
  logic [7:0]         ctl_q;
  logic               armed;
  logic               event_det;
  logic               busy;

  logic signed [31:0] a_p0, b_p0;
  logic [7:0]         ctl_p0;

  logic [32:0]        sum_u, dif_u;
  logic signed [32:0] sum_s, dif_s;
  logic [31:0]        c_nx;
  logic [3:0]         flags_nx;
  logic               err_nx;
  logic [7:0]         eb_nx;

  logic [31:0]        c_p1;
  logic [3:0]         flags_p1;
  logic               err_p1;
  logic [7:0]         eb_p1;
  logic [2:0]         crc3;

  // armed blocks a false event right after reset while CTL is still mid-packet
  assign event_det = armed && (ctl_q == IDLE_CTL) && (CTL != IDLE_CTL);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      ctl_q   <= IDLE_CTL;
      armed   <= 1'b0;
      ovf_cnt <= '0;
    end else begin
      state <= state_nx;
      ctl_q <= CTL;
      if (CTL == IDLE_CTL) armed <= 1'b1;
      if (busy && event_det) ovf_cnt <= sat_inc(ovf_cnt);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (event_det) state_nx = ST_EXEC;
      ST_EXEC: state_nx = ST_CRC;
      ST_CRC:  state_nx = ST_OUT;
      ST_OUT:  if (out_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // p0: operands captured on the event edge
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && event_det) begin
      a_p0   <= $signed(A);
      b_p0   <= $signed(B);
      ctl_p0 <= CTL;
    end
  end

  always_comb begin
    sum_u    = {1'b0, b_p0} + {1'b0, a_p0};
    dif_u    = {1'b0, b_p0} - {1'b0, a_p0};
    sum_s    = $signed({b_p0[31], b_p0}) + $signed({a_p0[31], a_p0});
    dif_s    = $signed({b_p0[31], b_p0}) - $signed({a_p0[31], a_p0});
    c_nx     = '0;
    flags_nx = '0;
    err_nx   = 1'b0;
    eb_nx    = ctl_p0;
    if (ctl_p0[7]) begin
      err_nx = 1'b1;
    end else begin
      case (ctl_p0[6:4])
        OP_AND: c_nx = a_p0 & b_p0;
        OP_OR:  c_nx = a_p0 | b_p0;
        OP_ADD: begin
          c_nx             = sum_u[31:0];
          flags_nx[FLAG_CY] = sum_u[32];
          flags_nx[FLAG_V]  = sum_s[32] ^ sum_s[31];
        end
        OP_SUB: begin
          c_nx             = dif_u[31:0];
          flags_nx[FLAG_CY] = dif_u[32];
          flags_nx[FLAG_V]  = dif_s[32] ^ dif_s[31];
        end
        default: begin
          err_nx = 1'b1;
          eb_nx  = ERR_OP;
        end
      endcase
      flags_nx[FLAG_Z] = (c_nx == 32'h0);
      flags_nx[FLAG_N] = c_nx[31];
    end
  end

  // p1: result and flags registered out of EXEC
  always_ff @(posedge clk) begin
    if (state == ST_EXEC) begin
      c_p1     <= c_nx;
      flags_p1 <= flags_nx;
      err_p1   <= err_nx;
      eb_p1    <= eb_nx;
    end
  end

  mtm_alu_crc3 u_crc3 (
    .data ({c_p1, 1'b0, flags_p1}),
    .crc  (crc3)
  );

  // p2: response registers, held until the next response is built
  always_ff @(posedge clk) begin
    if (!rst) begin
      C         <= '0;
      ctl_out   <= 8'hFF;
      err_out   <= 1'b0;
      out_valid <= 1'b0;
    end else if (state == ST_CRC) begin
      C         <= c_p1;
      ctl_out   <= err_p1 ? eb_p1 : {1'b0, flags_p1, crc3};
      err_out   <= err_p1;
      out_valid <= 1'b1;
    end else if (state == ST_OUT && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
